// File: rtl/vote_tally_fsm.sv
// vote_tally_fsm: session-based one-hot ballot collector with a sequential plurality scan.
// Define VOTE_INVALID_CNT_EN to add the saturating o_invalid_cnt output.
module vote_tally_fsm #(
    parameter int N_VOTERS = 5,
    parameter int N_CAND   = 3,
    parameter int CNT_W    = $clog2(N_VOTERS + 1),
    parameter int INV_W    = $clog2(N_VOTERS * 8 + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_close,
    input  logic [N_VOTERS-1:0]          i_vote_valid,
    input  logic [N_VOTERS*N_CAND-1:0]   i_vote_bus,
    output logic                         o_busy,
    output logic [N_VOTERS-1:0]          o_voted,
    output logic [CNT_W-1:0]             o_total,
    output logic                         o_result_valid,
    output logic [N_CAND-1:0]            o_winner,
    output logic                         o_tie
`ifdef VOTE_INVALID_CNT_EN
    ,
    output logic [INV_W-1:0]             o_invalid_cnt
`endif
);
    localparam int IDX_W = $clog2(N_CAND + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_TALLY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt [N_CAND];
    logic [N_VOTERS-1:0] r_voted;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_max;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_midx;
    logic                r_run_tie;
    logic [N_CAND-1:0]   r_winner;
    logic                r_tie;

    logic [N_VOTERS-1:0] w_onehot;
    logic [N_VOTERS-1:0] w_acc;
    logic [CNT_W-1:0]    w_inc [N_CAND];
    logic [CNT_W-1:0]    w_tot_inc;
    logic [CNT_W-1:0]    w_cur;
    logic                w_open;
    logic                w_start;
    logic                w_all;

    genvar v;
    for (v = 0; v < N_VOTERS; v++) begin : g_oh
        assign w_onehot[v] = $onehot(i_vote_bus[v*N_CAND +: N_CAND]);
    end

    assign w_open  = r_state == S_OPEN;
    assign w_acc   = w_open ? (i_vote_valid & ~r_voted & w_onehot) : '0;
    assign w_start = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_all   = &(r_voted | w_acc);

    // Per-candidate popcount of this cycle's accepted votes, plus the scan-candidate mux.
    always_comb begin
        w_tot_inc = '0;
        w_cur     = '0;
        for (int c = 0; c < N_CAND; c++) w_inc[c] = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            if (w_acc[i]) w_tot_inc = w_tot_inc + CNT_W'(1);
            for (int c = 0; c < N_CAND; c++)
                if (w_acc[i] && i_vote_bus[i*N_CAND + c]) w_inc[c] = w_inc[c] + CNT_W'(1);
        end
        for (int c = 0; c < N_CAND; c++)
            if (r_idx == IDX_W'(c)) w_cur = r_cnt[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_voted   <= '0;
            r_total   <= '0;
            r_max     <= '0;
            r_idx     <= '0;
            r_midx    <= '0;
            r_run_tie <= 1'b0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
            for (int c = 0; c < N_CAND; c++) r_cnt[c] <= '0;
        end else if (w_start) begin
            r_state   <= S_OPEN;
            r_voted   <= '0;
            r_total   <= '0;
            r_max     <= '0;
            r_idx     <= '0;
            r_midx    <= '0;
            r_run_tie <= 1'b0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
            for (int c = 0; c < N_CAND; c++) r_cnt[c] <= '0;
        end else if (w_open) begin
            r_voted <= r_voted | w_acc;
            r_total <= r_total + w_tot_inc;
            for (int c = 0; c < N_CAND; c++) r_cnt[c] <= r_cnt[c] + w_inc[c];
            if (i_close || w_all) begin
                r_state   <= S_TALLY;
                r_idx     <= '0;
                r_max     <= '0;
                r_midx    <= '0;
                r_run_tie <= 1'b0;
            end
        end else if (r_state == S_TALLY) begin
            // One extra cycle after the last candidate publishes the result.
            if (r_idx == IDX_W'(N_CAND)) begin
                r_state  <= S_DONE;
                r_winner <= (r_run_tie || r_max == '0) ? '0 : N_CAND'(1) << r_midx;
                r_tie    <= r_run_tie;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
                if (w_cur > r_max) begin
                    r_max     <= w_cur;
                    r_midx    <= r_idx;
                    r_run_tie <= 1'b0;
                end else if (w_cur == r_max && w_cur != '0) begin
                    r_run_tie <= 1'b1;
                end
            end
        end
    end

    assign o_busy         = r_state == S_OPEN || r_state == S_TALLY;
    assign o_result_valid = r_state == S_DONE;
    assign o_voted        = r_voted;
    assign o_total        = r_total;
    assign o_winner       = r_winner;
    assign o_tie          = r_tie;

`ifdef VOTE_INVALID_CNT_EN
    logic [N_VOTERS-1:0] w_bad;
    logic [INV_W:0]      w_inv_sum;
    logic [INV_W-1:0]    r_inv;

    assign w_bad = w_open ? (i_vote_valid & (~w_onehot | r_voted)) : '0;

    always_comb begin
        w_inv_sum = {1'b0, r_inv};
        for (int i = 0; i < N_VOTERS; i++)
            if (w_bad[i]) w_inv_sum = w_inv_sum + (INV_W + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_inv <= '0;
        else if (w_start) r_inv <= '0;
        else if (w_open)  r_inv <= w_inv_sum[INV_W] ? '1 : w_inv_sum[INV_W-1:0];
    end

    assign o_invalid_cnt = r_inv;
`endif
endmodule

// File: tb/tb_vote_tally_fsm.sv
// tb_vote_tally_fsm: directed checks of the 5x3 default configuration and an 8x4 instance.
module tb_vote_tally_fsm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_start, a_close;
    logic [4:0]  a_valid;
    logic [14:0] a_bus;
    logic        a_busy, a_rv, a_tie;
    logic [4:0]  a_voted;
    logic [2:0]  a_total;
    logic [2:0]  a_winner;

    logic        b_start, b_close;
    logic [7:0]  b_valid;
    logic [31:0] b_bus;
    logic        b_busy, b_rv, b_tie;
    logic [7:0]  b_voted;
    logic [3:0]  b_total;
    logic [3:0]  b_winner;

`ifdef VOTE_INVALID_CNT_EN
    logic [5:0]  a_inv;
    logic [6:0]  b_inv;
`endif

    int checks = 0;
    int errors = 0;

    vote_tally_fsm u_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_close(a_close),
        .i_vote_valid(a_valid), .i_vote_bus(a_bus),
`ifdef VOTE_INVALID_CNT_EN
        .o_invalid_cnt(a_inv),
`endif
        .o_busy(a_busy), .o_voted(a_voted), .o_total(a_total),
        .o_result_valid(a_rv), .o_winner(a_winner), .o_tie(a_tie)
    );

    vote_tally_fsm #(.N_VOTERS(8), .N_CAND(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_close(b_close),
        .i_vote_valid(b_valid), .i_vote_bus(b_bus),
`ifdef VOTE_INVALID_CNT_EN
        .o_invalid_cnt(b_inv),
`endif
        .o_busy(b_busy), .o_voted(b_voted), .o_total(b_total),
        .o_result_valid(b_rv), .o_winner(b_winner), .o_tie(b_tie)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic va(input int v, input logic [2:0] f);
        a_valid = 5'b1 << v;
        a_bus   = 15'(f) << (v * 3);
        tick();
        a_valid = '0;
        a_bus   = '0;
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_pulse_close();
        a_close = 1'b1;
        tick();
        a_close = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_close = 0; a_valid = '0; a_bus = '0;
        b_start = 0; b_close = 0; b_valid = '0; b_bus = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_voted", a_voted, 0);
        chk("rst_total", a_total, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_winner", a_winner, 0);
        chk("rst_tie", a_tie, 0);

        a_pulse_close();
        chk("close_idle_ignored", a_busy, 0);

        // Session 1: all five vote in one cycle -> auto-close.
        a_pulse_start();
        chk("s1_busy", a_busy, 1);
        a_valid = 5'b11111;
        a_bus   = {3'b001, 3'b100, 3'b010, 3'b001, 3'b001};
        tick();
        a_valid = '0; a_bus = '0;
        chk("s1_voted", a_voted, 5'b11111);
        chk("s1_total_early", a_total, 5);
        tick(); tick(); tick();
        chk("s1_rv_not_yet", a_rv, 0);
        chk("s1_busy_tally", a_busy, 1);
        tick();
        chk("s1_rv", a_rv, 1);
        chk("s1_busy_fall", a_busy, 0);
        chk("s1_winner", a_winner, 3'b001);
        chk("s1_tie", a_tie, 0);
        chk("s1_total", a_total, 5);

        // Session 2: 2-2 tie over four cycles, explicit close.
        a_pulse_start();
        chk("s2_cleared_voted", a_voted, 0);
        chk("s2_cleared_rv", a_rv, 0);
        chk("s2_cleared_winner", a_winner, 0);
        va(0, 3'b001); va(1, 3'b010); va(2, 3'b001); va(3, 3'b010);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("s2_start_in_open_keeps", a_total, 4);
        a_pulse_close();
        tick(); tick(); tick(); tick();
        chk("s2_rv", a_rv, 1);
        chk("s2_winner", a_winner, 0);
        chk("s2_tie", a_tie, 1);
        chk("s2_total", a_total, 4);

        // Session 3: repeat vote and non-one-hot vote ignored.
        a_pulse_start();
        va(2, 3'b100); va(2, 3'b010); va(3, 3'b011);
        a_pulse_close();
        tick(); tick(); tick(); tick();
        chk("s3_voted", a_voted, 5'b00100);
        chk("s3_total", a_total, 1);
        chk("s3_winner", a_winner, 3'b100);
        chk("s3_tie", a_tie, 0);
`ifdef VOTE_INVALID_CNT_EN
        chk("s3_invalid_cnt", a_inv, 2);
`endif

        // Session 4: empty session.
        a_pulse_start();
        a_pulse_close();
        tick(); tick(); tick();
        chk("s4_rv_not_yet", a_rv, 0);
        tick();
        chk("s4_rv", a_rv, 1);
        chk("s4_winner", a_winner, 0);
        chk("s4_tie", a_tie, 0);
        chk("s4_total", a_total, 0);

        // Session 5: reset mid-TALLY, then a clean session.
        a_pulse_start();
        a_valid = 5'b00011;
        a_bus   = {3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        tick();
        a_valid = '0; a_bus = '0;
        a_pulse_close();
        tick();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy", a_busy, 0);
        chk("s5_rst_voted", a_voted, 0);
        chk("s5_rst_total", a_total, 0);
        chk("s5_rst_rv", a_rv, 0);
        #3;
        rst_n = 1'b1;
        tick();
        tick(); tick(); tick(); tick();
        chk("s5_stays_idle", a_rv, 0);
        a_pulse_start();
        va(0, 3'b010); va(1, 3'b100); va(2, 3'b010);
        a_pulse_close();
        tick(); tick(); tick(); tick();
        chk("s5_rv", a_rv, 1);
        chk("s5_winner", a_winner, 3'b010);
        chk("s5_tie", a_tie, 0);
        chk("s5_total", a_total, 3);

        // Instance B (8 voters, 4 candidates): counts 3,3,1,1, last votes with close.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 8'b0001_1111;
        b_bus   = {4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
        tick();
        chk("b_total_mid", b_total, 5);
        b_valid = 8'b1110_0000;
        b_bus   = {4'b1000, 4'b0100, 4'b0010, 20'h0};
        b_close = 1'b1;
        tick();
        b_valid = '0; b_bus = '0; b_close = 1'b0;
        chk("b_voted", b_voted, 8'hff);
        chk("b_total", b_total, 8);
        tick(); tick(); tick(); tick();
        chk("b_rv_not_yet", b_rv, 0);
        tick();
        chk("b_rv", b_rv, 1);
        chk("b_winner", b_winner, 0);
        chk("b_tie", b_tie, 1);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_restart_rv", b_rv, 0);
        chk("b_restart_tie", b_tie, 0);
        chk("b_restart_total", b_total, 0);
        chk("b_restart_voted", b_voted, 0);
        chk("b_restart_busy", b_busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
